instr_loader: RTL

Boot-time loader that writes the program image into the writable instruction RAM before the pipeline runs. It takes a byte stream from a host or UART bridge over a valid/ready handshake and packs every four bytes into a little-endian 32-bit instruction. It writes each instruction to consecutive word-aligned byte addresses starting at 0, and holds the processor in reset until the image is complete.

---
 rtl/instr_loader.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Boot-time loader for the writable instruction RAM. Bytes arrive over a
// valid/ready stream and are packed four at a time, little-endian, into 32-bit
// instructions. Each instruction is written to the next word-aligned byte
// address starting at 0. The processor is held in reset until the whole image
// has been written.
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//   When defined, the loader keeps a running XOR of every written word. After
//   the last write it accepts four more bytes as a checksum word and finishes
//   in DONE on a match or ERR on a mismatch. When undefined there is no CHECK
//   state and no checksum logic.
//
// Parameters:
//   INSTRUCT_MEM_SIZE  instruction memory size in bytes (power of two, > 4)
//   CW                 width of the word counter
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin a session (honoured only in IDLE, DONE, ERR)
//   word_count  in   number of instructions, latched on an accepted start
//   byte_valid  in   byte_data is valid
//   byte_data   in   stream byte
//   byte_ready  out  a byte is accepted this cycle if byte_valid is high
//   wr_en       out  instruction RAM write strobe
//   wr_addr     out  word-aligned byte address of the write
//   wr_data     out  assembled instruction
//   busy        out  session in progress
//   done        out  image loaded successfully (sticky)
//   error       out  session rejected or failed (sticky)
//   cpu_hold    out  holds the processor in reset
// -----------------------------------------------------------------------------
module instr_loader #(
   parameter int INSTRUCT_MEM_SIZE = 1024,
   parameter int CW                = $clog2(INSTRUCT_MEM_SIZE / 4) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] word_count,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          wr_en,
   output logic [63:0]   wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          cpu_hold
);

   localparam logic [CW-1:0] MAX_WORDS = CW'(INSTRUCT_MEM_SIZE / 4);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
`ifdef INSTR_LOADER_CHECKSUM_EN
      , CHECK = 3'd5
`endif
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [1:0]    byte_idx_r;
   logic [CW-1:0] word_idx_r;
   logic [CW-1:0] word_cnt_r;
   logic [23:0]   partial_r;

   logic          accept_s;
   logic          last_byte_s;
   logic          last_word_s;
   logic          count_ok_s;
   logic          idle_like_s;
   logic          session_start_s;

   // Completes a little-endian word: the incoming byte is the most significant.
   function automatic logic [31:0] pack_word(input logic [23:0] low, input logic [7:0] top);
      return {top, low};
   endfunction

   // Byte address of a word index; the two low bits are always zero.
   function automatic logic [63:0] word_addr(input logic [CW-1:0] idx);
      return 64'({idx, 2'b00});
   endfunction

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [31:0] csum_r;

   // Running XOR checksum step.
   function automatic logic [31:0] xor_fold(input logic [31:0] acc, input logic [31:0] word);
      return acc ^ word;
   endfunction
`endif

   assign accept_s        = byte_valid & byte_ready;
   assign last_byte_s     = (byte_idx_r == 2'd3);
   assign last_word_s     = ((word_idx_r + {{(CW-1){1'b0}}, 1'b1}) == word_cnt_r);
   assign count_ok_s      = (word_count != {CW{1'b0}}) && (word_count <= MAX_WORDS);
   assign idle_like_s     = (state_r == IDLE) || (state_r == DONE) || (state_r == ERR);
   assign session_start_s = idle_like_s & start & count_ok_s;

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start) begin
               if (count_ok_s) begin
                  state_next_s = RECV;
               end else begin
                  state_next_s = ERR;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         RECV: begin
            if (accept_s && last_byte_s) begin
               state_next_s = WRITE;
            end else begin
               state_next_s = RECV;
            end
         end
         WRITE: begin
            if (last_word_s) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               state_next_s = CHECK;
`else
               state_next_s = DONE;
`endif
            end else begin
               state_next_s = RECV;
            end
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept_s && last_byte_s) begin
               if (pack_word(partial_r, byte_data) == csum_r) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = ERR;
               end
            end else begin
               state_next_s = CHECK;
            end
         end
`endif
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Status outputs, registered by decoding the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
         byte_ready <= (state_next_s == RECV) || (state_next_s == CHECK);
         busy       <= (state_next_s == RECV) || (state_next_s == WRITE) || (state_next_s == CHECK);
`else
         byte_ready <= (state_next_s == RECV);
         busy       <= (state_next_s == RECV) || (state_next_s == WRITE);
`endif
         wr_en      <= (state_next_s == WRITE);
         done       <= (state_next_s == DONE);
         error      <= (state_next_s == ERR);
         cpu_hold   <= (state_next_s != DONE);
      end
   end

   // Session bookkeeping: word count, byte/word indices and the partial word.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt_r <= {CW{1'b0}};
         byte_idx_r <= 2'd0;
         word_idx_r <= {CW{1'b0}};
         partial_r  <= 24'd0;
      end else if (session_start_s) begin
         word_cnt_r <= word_count;
         byte_idx_r <= 2'd0;
         word_idx_r <= {CW{1'b0}};
         partial_r  <= 24'd0;
      end else begin
         if (accept_s) begin
            // Two-bit index wraps to 0 after the fourth byte.
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
               2'd0:    partial_r[7:0]   <= byte_data;
               2'd1:    partial_r[15:8]  <= byte_data;
               2'd2:    partial_r[23:16] <= byte_data;
               default: partial_r        <= partial_r;
            endcase
         end
         if (state_r == WRITE) begin
            word_idx_r <= word_idx_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Write address and data are captured with the fourth byte and held until the next word.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr <= 64'd0;
         wr_data <= 32'd0;
      end else if ((state_r == RECV) && accept_s && last_byte_s) begin
         wr_addr <= word_addr(word_idx_r);
         wr_data <= pack_word(partial_r, byte_data);
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   // Running checksum over every word as it is written.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum_r <= 32'd0;
      end else if (session_start_s) begin
         csum_r <= 32'd0;
      end else if (state_r == WRITE) begin
         csum_r <= xor_fold(csum_r, wr_data);
      end
   end
`endif

endmodule
